// File: rtl/xor32_arbiter_pkg.sv
// rtl/xor32_arbiter_pkg.sv - shared FSM encodings and widths for the xor32 arbiter
package xor32_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int OP_CNT_W = 16;

endpackage

// File: rtl/xor32_arbiter_if.sv
// rtl/xor32_arbiter_if.sv - request/response bundle between clients and the xor32 arbiter
interface xor32_arbiter_if
    import xor32_arb_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    logic [OP_CNT_W-1:0]      op_count;

    // Client side: drives operands and consumes responses.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, op_count
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, op_count
    );

endinterface

// File: rtl/xor32.sv
// rtl/xor32.sv - shared combinational XOR unit
module xor32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor32_arbiter_rr_grant.sv
// rtl/xor32_arbiter_rr_grant.sv - combinational round-robin picker starting at ptr_i
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin : pick
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Scan ptr, ptr+1, ... wrapping; first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/xor32_arbiter.sv
// rtl/xor32_arbiter.sv - round-robin arbiter sharing one XOR datapath; op counter under XOR32_ARB_STATS_EN
module xor32_arbiter
    import xor32_arb_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    xor32_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [WIDTH-1:0]    op_a_q;
    logic [WIDTH-1:0]    op_b_q;
    logic [WIDTH-1:0]    resp_data_q;
    logic [ID_W-1:0]     resp_id_q;
    logic                resp_valid_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [WIDTH-1:0]    xor_res;
    logic                accept;
    logic                resp_hs;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    xor32 #(
        .WIDTH (WIDTH)
    ) u_xor (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (xor_res)
    );

    // rst_n gates the grant so no requester sees ready while reset is held.
    assign accept        = (state_q == ST_IDLE) && gnt_any && rst_n;
    assign bus.req_ready = accept ? gnt : '0;
    assign resp_hs       = resp_valid_q & bus.resp_ready;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q  <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
                        op_b_q  <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
                        id_q    <= gnt_idx;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data_q  <= xor_res;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_hs) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef XOR32_ARB_STATS_EN
    logic [OP_CNT_W-1:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (resp_hs) begin
            op_count_q <= op_count_q + 1'b1;
        end
    end

    assign bus.op_count = op_count_q;
`else
    assign bus.op_count = '0;
`endif

endmodule

// File: tb/tb_xor32_arbiter.sv
// tb/tb_xor32_arbiter.sv - directed self-checking bench for xor32_arbiter
module tb_xor32_arbiter;

`ifdef XOR32_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   ops;

    xor32_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    xor32_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'h0;
    endfunction

    // One full operation with resp_ready held high: grant, EXEC, RESP, handshake.
    task automatic run_op(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic [31:0] d);
        @(negedge clk);
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(g));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_exec_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_exec_valid"}, 32'(bus.resp_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h1);
        chk({tag, "_resp_data"}, bus.resp_data, d);
        chk({tag, "_resp_id"}, 32'(bus.resp_id), 32'(id));
        @(posedge clk); #1;
        ops++;
        chk({tag, "_op_count"}, 32'(bus.op_count), exp_cnt(ops));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ops    = 0;
        rst_n  = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b0;
        // Per-requester operands: 0 -> AAAAAAAA, 1 -> EDCBA987, 2 -> F0F00F0F, 3 -> 21524110
        bus.req_a = {32'hDEADBEEF, 32'hFFFF0000, 32'h12345678, 32'hAAAA5555};
        bus.req_b = {32'hFFFFFFFF, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0000FFFF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'h0);
        chk("rst_op_count", 32'(bus.op_count), 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request from requester 2
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b1;
        run_op("single", 4'b0100, 2'd2, 32'hF0F00F0F);

        // Pointer now 3: 3 first, then wrap to 0
        bus.req_valid = 4'b1001;
        run_op("wrap3", 4'b1000, 2'd3, 32'h21524110);
        run_op("wrap0", 4'b0001, 2'd0, 32'hAAAAAAAA);

        // Backpressure on requester 1 while all others wait
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("bp_exec_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'h1);
            chk("bp_data", bus.resp_data, 32'hEDCBA987);
            chk("bp_id", 32'(bus.resp_id), 32'h1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        ops++;
        chk("bp_op_count", 32'(bus.op_count), exp_cnt(ops));
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h4);
        chk("bp_valid_clear", 32'(bus.resp_valid), 32'h0);

        // Reset while in EXEC
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rexec_valid", 32'(bus.resp_valid), 32'h0);
        chk("rexec_op_count", 32'(bus.op_count), 32'h0);
        chk("rexec_req_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 4'b0000;
        ops = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rexec_no_resp", 32'(bus.resp_valid), 32'h0);
            chk("rexec_cnt_zero", 32'(bus.op_count), 32'h0);
        end
        @(posedge clk); #1;

        // All four continuously valid: order 0,1,2,3,0
        bus.req_valid = 4'b1111;
        run_op("all0", 4'b0001, 2'd0, 32'hAAAAAAAA);
        run_op("all1", 4'b0010, 2'd1, 32'hEDCBA987);
        run_op("all2", 4'b0100, 2'd2, 32'hF0F00F0F);
        chk("three_ops_count", 32'(bus.op_count), STATS ? 32'h3 : 32'h0);
        run_op("all3", 4'b1000, 2'd3, 32'h21524110);
        run_op("all4", 4'b0001, 2'd0, 32'hAAAAAAAA);
        bus.req_valid = 4'b0000;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor32_arbiter.md
Name: xor32_arbiter

Overview:
- Shares one 32-bit XOR datapath (A ^ B) between NUM_REQ requesters.
- Each request is an operand pair plus a valid/ready handshake.
- Arbitration is round-robin, with one operation in flight at a time.
- The result is registered and returned with the requester ID through a valid/ready response channel. The block sits between ALU-side clients (checksum, scrambler, CPU helper) and the shared XOR unit.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 32, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), width of the requester index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i presents an operand pair.
- req_ready  output  NUM_REQ  bit i: requester i is granted and accepted this cycle (one-hot or zero).
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  WIDTH  A ^ B of the accepted request.
- resp_id  output  ID_W  index of the requester that owns resp_data.
- op_count  output  16  completed-operation counter (see Optional Feature).

Behaviour:
- FSM states:
  - IDLE: accept a request.
  - EXEC: XOR the latched operands into the result register.
  - RESP: hold the result until it is taken.
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0, resp_id=0, op_count=0. req_ready=0 while reset is asserted.
- Grant in IDLE:
  - Combinational.
  - Picks the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - Only that bit of req_ready is 1. req_ready is all 0 in EXEC and RESP, and all 0 in IDLE when there is no valid.
- Accept: on an edge with req_valid[g] & req_ready[g], latch req_a/req_b slice g into op registers, latch g into id_q, then go to EXEC.
- EXEC (1 cycle): resp_data <= op_a ^ op_b, resp_id <= id_q, resp_valid <= 1, then go to RESP.
- RESP:
  - resp_valid, resp_data and resp_id are held stable until resp_valid & resp_ready.
  - On that edge: resp_valid <= 0, rr_ptr <= (id_q == NUM_REQ-1) ? 0 : id_q+1, then go to IDLE.
- Latency: accept edge to resp_valid=1 is 2 cycles. Minimum spacing between accepts is 3 cycles when resp_ready is held at 1.
- Fairness: a continuously valid requester is granted within NUM_REQ operations.
- Requesters may drop req_valid before being granted, with no side effect. Requesters must not make req_valid depend on req_ready.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset mid-operation aborts the operation: the latched operands are discarded and no response is produced.
- No arithmetic widening: resp_data is exactly WIDTH bits.
- Unused state encodings return to IDLE.

Optional Feature:
- Macro XOR32_ARB_STATS_EN.
- Defined: op_count is a 16-bit counter, incremented on each response handshake. It wraps 0xFFFF -> 0x0000 and is cleared by reset.
- Undefined: op_count is tied to 16'h0000 and the counter logic is absent. The port list is unchanged.

Decomposition:
- Shared package/header xor32_arb_defs: state encodings (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2) and the op_count width constant (16).
- One sub-module, rr_grant: a combinational round-robin picker with inputs req (NUM_REQ) and ptr (ID_W), and outputs a one-hot grant plus its index.
- The shared XOR itself is instantiated as the existing xor32 unit.

Test Plan:
- Single request: req_valid=4'b0100, a=32'hFFFF0000, b=32'h0F0F0F0F, resp_ready=1.
  - req_ready=4'b0100 in the same cycle.
  - 2 cycles later: resp_valid=1, resp_data=32'hF0F00F0F, resp_id=2.
  - rr_ptr becomes 3.
- All four valid continuously with resp_ready=1: grant order is 0,1,2,3,0 and each requester is served once per 4 operations.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - resp_data and resp_id stay stable.
  - req_ready stays 0000.
  - The next accept occurs only after the handshake.
- Wrap: rr_ptr=3 with req_valid=4'b1001.
  - Requester 3 is granted first, then requester 0.
  - After serving 3, rr_ptr wraps to 0.
- Reset in EXEC: rst_n=0 for 1 cycle.
  - resp_valid=0 and op_count=0 immediately (async).
  - No response is emitted.
  - The next grant starts from requester 0.
- With XOR32_ARB_STATS_EN: after 3 completed operations, op_count=3. Without the macro, op_count=0 throughout.
